e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//  Multiply/divide unit of the E stage. It consumes the instruction operands held by the ID/EX pipeline register.
//  It executes MULT/MULTU/DIV/DIVU over a multi-cycle busy window and owns the architectural HI/LO registers.
//  It serves MFHI/MFLO reads and MTHI/MTLO writes.
//  It exports start/busy to the hazard unit, which stalls D-stage MD instructions; results feed the EX/MEM register.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after a MULT/MULTU start (>=1)
//  DIV_CYCLES   10  busy cycles after a DIV/DIVU start (>=1)
// PORTS
//  clk      in   1   clock, rising edge
//  reset    in   1   asynchronous, active-low reset
//  md_op    in   4   E-stage MD opcode (mdu_pkg encoding)
//  rs_in    in   32  forwarded rs operand
//  rt_in    in   32  forwarded rt operand
//  req      in   1   exception/interrupt flush in this cycle
//  start    out  1   combinational: a mult/div is accepted this cycle
//  busy     out  1   registered: a mult/div is in flight
//  rd_data  out  32  MFHI->HI, MFLO->LO, otherwise 0 (combinational)
//  hi_out   out  32  current HI register
//  lo_out   out  32  current LO register
// BEHAVIOUR
//  - Reset (reset==0, asynchronous): HI=0, LO=0, busy=0, counter=0, pending result=0. Effective immediately, including mid-operation.
//  - Ops: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO. Unlisted codes are treated as NONE.
//  - start = md_op in {MULT,MULTU,DIV,DIVU} && !busy && !req.
//  - On a start edge:
//    - Compute the 64-bit result from rs_in/rt_in into pending {hi_p,lo_p}.
//    - Load counter with MULT_CYCLES or DIV_CYCLES; set busy=1.
//  - While busy, the counter decrements each edge. On the edge where counter==1: HI<=hi_p, LO<=lo_p, busy<=0.
//  - busy is therefore high for exactly N cycles following the start cycle. New HI/LO are visible in the cycle busy drops.
//  - MULT: signed 32x32->64, {HI,LO}=product. MULTU: unsigned.
//  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend. DIVU: unsigned.
//  - Divide by zero: the busy window runs the full DIV_CYCLES; HI/LO are left unchanged at completion.
//  - MTHI/MTLO: write rs_in to HI/LO at the edge when !busy && !req. Ignored while busy (the hazard unit guarantees this never happens).
//  - MFHI/MFLO: rd_data reflects the HI/LO register value, not pending data.
//  - MFHI/MFLO while busy is a hazard-unit error; rd_data still shows the old value.
//  - req: suppresses start and MTHI/MTLO in the same cycle. It does NOT abort an operation already busy; that operation completes normally.
//  - MD start while busy: ignored (no restart, no counter reload).
//  - Simultaneous completion edge and MTHI/MTLO: busy is still 1 on that edge, so the MT write is ignored and the completion writes win.
//  - Back-to-back: a new start is accepted in the cycle busy==0, i.e. the cycle after completion.
// STRUCTURE
//  - mdu_pkg: md_op encodings (4-bit localparams), helper is_md_start(op).
//  - No sub-module. Single always block, async reset: HI, LO, hi_p, lo_p, counter[3:0], busy.
//  - Combinational: start, rd_data.
// TESTING
//  1 MULT rs=FFFFFFFD(-3) rt=5 -> busy 5 cycles; then HI=FFFFFFFF, LO=FFFFFFF1.
//  2 DIVU rs=7 rt=2 -> busy 10 cycles; then LO=3, HI=1. DIV rs=FFFFFFF9 rt=2 -> LO=FFFFFFFD, HI=FFFFFFFF.
//  3 MULTU rs=FFFFFFFF rt=FFFFFFFF -> HI=FFFFFFFE, LO=00000001. Then MFHI -> rd_data=FFFFFFFE.
//  4 MULT with req=1 in the start cycle -> start=0, busy stays 0, HI/LO unchanged. MTLO rs=1234 with req=1 -> LO unchanged.
//  5 DIV rt=0 with HI=AA, LO=BB -> busy 10 cycles; HI=AA, LO=BB. MTHI issued mid-busy -> ignored.
//  6 reset=0 asserted at busy cycle 3 of a DIV -> busy=0, HI=LO=0 without waiting for a clock edge; no write after release.

Source files
------------

// File: rtl/mdu_pkg.sv
// Package for the E-stage multiply/divide unit.
// Holds the 4-bit md_op encodings decoded by e_mdu and a helper that
// identifies the opcodes which open a multi-cycle busy window.
package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  // True for the opcodes that start a multiply or divide.
  function automatic logic is_md_start(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: is_md_start = 1'b1;
      default:                            is_md_start = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with architectural HI/LO registers.
// The 64-bit result is computed in the start cycle and parked in a pending
// register; it is committed to HI/LO when the busy countdown expires.
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-low reset
//   md_op    - E-stage MD opcode (mdu_pkg encoding)
//   rs_in    - forwarded rs operand
//   rt_in    - forwarded rt operand
//   req      - exception/interrupt flush this cycle
//   start    - combinational: a mult/div is accepted this cycle
//   busy     - registered: a mult/div is in flight
//   rd_data  - MFHI->HI, MFLO->LO, otherwise 0
//   hi_out   - current HI register
//   lo_out   - current LO register
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_in,
  input  logic [31:0] rt_in,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hi_p;
  logic [31:0] lo_p;
  logic        pend_wr;
  logic [3:0]  counter;

  logic        is_sdiv;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [63:0] calc;
  logic        calc_wr;

  assign start  = is_md_start(md_op) && !busy && !req;
  assign hi_out = hi;
  assign lo_out = lo;

  // Result datapath. Signed divide runs on magnitudes so that the
  // 0x80000000 / -1 corner has a well-defined result (quotient 0x80000000).
  always_comb begin
    is_sdiv  = (md_op == MD_DIV);
    dividend = (is_sdiv && rs_in[31]) ? (32'd0 - rs_in) : rs_in;
    divisor  = (is_sdiv && rt_in[31]) ? (32'd0 - rt_in) : rt_in;
    if (divisor == 32'd0) begin
      uq = 32'd0;
      ur = 32'd0;
    end else begin
      uq = dividend / divisor;
      ur = dividend % divisor;
    end
    quo = (is_sdiv && (rs_in[31] ^ rt_in[31])) ? (32'd0 - uq) : uq;
    rem = (is_sdiv && rs_in[31]) ? (32'd0 - ur) : ur;
    case (md_op)
      MD_MULT: begin
        calc    = {{32{rs_in[31]}}, rs_in} * {{32{rt_in[31]}}, rt_in};
        calc_wr = 1'b1;
      end
      MD_MULTU: begin
        calc    = {32'd0, rs_in} * {32'd0, rt_in};
        calc_wr = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        calc    = {rem, quo};
        // divide by zero still burns the busy window but never commits
        calc_wr = (rt_in != 32'd0);
      end
      default: begin
        calc    = 64'd0;
        calc_wr = 1'b0;
      end
    endcase
  end

  // Read mux for MFHI/MFLO; always the committed registers, never pending data.
  always_comb begin
    case (md_op)
      MD_MFHI: rd_data = hi;
      MD_MFLO: rd_data = lo;
      default: rd_data = 32'd0;
    endcase
  end

  // HI/LO, pending result, countdown and busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      hi_p    <= 32'd0;
      lo_p    <= 32'd0;
      pend_wr <= 1'b0;
      counter <= 4'd0;
      busy    <= 1'b0;
    end else if (busy) begin
      // MT writes and new starts are ignored while busy; completion wins.
      if (counter == 4'd1) begin
        busy    <= 1'b0;
        counter <= 4'd0;
        if (pend_wr) begin
          hi <= hi_p;
          lo <= lo_p;
        end
      end else begin
        counter <= counter - 4'd1;
      end
    end else if (start) begin
      hi_p    <= calc[63:32];
      lo_p    <= calc[31:0];
      pend_wr <= calc_wr;
      counter <= ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? MULT_CNT : DIV_CNT;
      busy    <= 1'b1;
    end else if (!req) begin
      if (md_op == MD_MTHI) begin
        hi <= rs_in;
      end
      if (md_op == MD_MTLO) begin
        lo <= rs_in;
      end
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu. Expected HI/LO pairs are computed by a
// 64-bit reference model when an operation is issued, queued, and popped
// when busy falls.
module tb_e_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] rs_in;
  logic [31:0] rt_in;
  logic        req;
  logic        start;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  logic [63:0] sb_q[$];
  logic [31:0] mdl_hi;
  logic [31:0] mdl_lo;
  int checks = 0;
  int failures = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .rs_in(rs_in), .rt_in(rt_in),
    .req(req), .start(start), .busy(busy), .rd_data(rd_data),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sa, sb, p, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT: begin
        p = sa * sb;
        return 64'(p);
      end
      MD_MULTU: return ua * ub;
      MD_DIV: begin
        if (b == 32'd0) return {h, l};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      MD_DIVU: begin
        if (b == 32'd0) return {h, l};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return {h, l};
    endcase
  endfunction

  // Drive one op for one clock edge (called at a negedge while not busy).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic r, input logic exp_start, input string name);
    md_op = op; rs_in = a; rt_in = b; req = r;
    #1;
    checks++;
    if (start !== exp_start) begin
      failures++;
      $display("FAIL %s start: got %b expected %b", name, start, exp_start);
    end
    if (exp_start) begin
      sb_q.push_back(model(op, a, b, mdl_hi, mdl_lo));
    end else if (!r && op == MD_MTHI) begin
      mdl_hi = a;
    end else if (!r && op == MD_MTLO) begin
      mdl_lo = a;
    end
    @(negedge clk);
    md_op = MD_NONE; req = 1'b0;
  endtask

  // Count busy cycles, optionally inject a side op at cycle side_at, then
  // compare HI/LO against the scoreboard head.
  task automatic wait_done(input int cycles, input logic [3:0] side_op, input int side_at,
                           input string name);
    int n = 0;
    logic [63:0] exp;
    while (busy === 1'b1 && n < 40) begin
      if (n == side_at) begin
        md_op = side_op; rs_in = 32'h55;
        #1;
        if (is_md_start(side_op)) begin
          checks++;
          if (start !== 1'b0) begin
            failures++;
            $display("FAIL %s start_while_busy: got %b expected 0", name, start);
          end
        end
      end else begin
        md_op = MD_NONE;
      end
      @(negedge clk);
      n++;
    end
    md_op = MD_NONE;
    checks++;
    if (n != cycles) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, cycles);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard: got empty expected entry", name);
    end else begin
      exp = sb_q.pop_front();
      mdl_hi = exp[63:32];
      mdl_lo = exp[31:0];
      if (hi_out !== exp[63:32] || lo_out !== exp[31:0]) begin
        failures++;
        $display("FAIL %s hilo: got %h_%h expected %h_%h", name, hi_out, lo_out,
                 exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic check32(input logic [31:0] got, input logic [31:0] exp, input string name);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; md_op = MD_NONE; rs_in = 32'd0; rt_in = 32'd0; req = 1'b0;
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    repeat (3) @(negedge clk);
    check32({31'd0, busy}, 32'd0, "reset busy");
    check32(hi_out, 32'd0, "reset hi");
    check32(lo_out, 32'd0, "reset lo");
    reset = 1'b1;
    @(negedge clk);
    check32(rd_data, 32'd0, "rd_data none");
  endtask

  task automatic test_mult();
    issue(MD_MULT, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b1, "mult");
    // MTLO on the completion edge must lose to the result write
    wait_done(5, MD_MTLO, 4, "mult");
    check32(hi_out, 32'hFFFFFFFF, "mult hi const");
    check32(lo_out, 32'hFFFFFFF1, "mult lo const");
  endtask

  task automatic test_div();
    issue(MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b1, "divu");
    wait_done(10, MD_NONE, -1, "divu");
    check32(lo_out, 32'd3, "divu lo const");
    check32(hi_out, 32'd1, "divu hi const");
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, "div");
    wait_done(10, MD_NONE, -1, "div");
    check32(lo_out, 32'hFFFFFFFD, "div lo const");
    check32(hi_out, 32'hFFFFFFFF, "div hi const");
  endtask

  task automatic test_multu_mfhi();
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, "multu");
    wait_done(5, MD_NONE, -1, "multu");
    md_op = MD_MFHI; #1;
    check32(rd_data, 32'hFFFFFFFE, "mfhi rd_data");
    md_op = MD_MFLO; #1;
    check32(rd_data, 32'h00000001, "mflo rd_data");
    md_op = MD_NONE;
    @(negedge clk);
  endtask

  task automatic test_req();
    issue(MD_MULT, 32'd3, 32'd4, 1'b1, 1'b0, "mult req");
    check32({31'd0, busy}, 32'd0, "req busy");
    issue(MD_MTLO, 32'h1234, 32'd0, 1'b1, 1'b0, "mtlo req");
    check32(hi_out, 32'hFFFFFFFE, "req hi");
    check32(lo_out, 32'h00000001, "req lo");
  endtask

  task automatic test_div_zero();
    issue(MD_MTHI, 32'hAA, 32'd0, 1'b0, 1'b0, "mthi");
    issue(MD_MTLO, 32'hBB, 32'd0, 1'b0, 1'b0, "mtlo");
    check32(hi_out, 32'hAA, "mthi write");
    issue(MD_DIV, 32'd9, 32'd0, 1'b0, 1'b1, "div0");
    wait_done(10, MD_MTHI, 2, "div0");
    check32(hi_out, 32'hAA, "div0 hi const");
    check32(lo_out, 32'hBB, "div0 lo const");
  endtask

  task automatic test_async_reset();
    issue(MD_MTHI, 32'h1111, 32'd0, 1'b0, 1'b0, "mthi pre");
    issue(MD_MTLO, 32'h2222, 32'd0, 1'b0, 1'b0, "mtlo pre");
    issue(MD_DIV, 32'd100, 32'd7, 1'b0, 1'b1, "div rst");
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check32({31'd0, busy}, 32'd0, "async busy");
    check32(hi_out, 32'd0, "async hi");
    check32(lo_out, 32'd0, "async lo");
    sb_q.delete();
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check32({31'd0, busy}, 32'd0, "post reset busy");
    check32(hi_out, 32'd0, "post reset hi");
    check32(lo_out, 32'd0, "post reset lo");
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0: op = MD_MULT;
        1: op = MD_MULTU;
        2: op = MD_DIV;
        default: op = MD_DIVU;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : $urandom;
      if (i == 0) begin op = MD_DIV; a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (i == 3) begin op = MD_DIVU; b = 32'd0; end
      if (i == 5) begin op = MD_DIV; a = 32'hFFFFFF9C; b = 32'hFFFFFFF9; end
      issue(op, a, b, 1'b0, 1'b1, "b2b");
      wait_done((op == MD_MULT || op == MD_MULTU) ? 5 : 10, MD_MULT, 1, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_multu_mfhi();
    test_req();
    test_div_zero();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
